// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between a single-cycle core's data port and a
// word-wide valid/ready memory bus. Each core access becomes one aligned bus
// transaction (request phase, then response phase). While the access is in
// flight, the core is stalled. Loads return sign- or zero-extended data.
// Misaligned accesses, illegal memops and bus timeouts complete with a
// one-cycle error pulse.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   cpu_ren/wen     load / store request; a store wins when both are high
//   cpu_memop       funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   cpu_addr        byte address
//   cpu_wdata       store data
//   cpu_rdata       registered, extended load data
//   cpu_stall       holds the core while an access is outstanding
//   cpu_err         one-cycle fault pulse in the commit cycle
//   bus_req_*       request handshake; payload is bus_we/addr/wdata/wstrb
//   bus_resp_valid  one-cycle response pulse; bus_rdata is valid with it
module riscv_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ren,
  input  logic        cpu_wen,
  input  logic [2:0]  cpu_memop,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  // The counter value on the last cycle allowed in REQ+RESP.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  memop_q, memop_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_err_q, cpu_err_d;
  logic        bus_req_valid_q, bus_req_valid_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;

  logic        cpu_req;
  logic        req_fault;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_strb;
  logic [31:0] load_shifted;
  logic [31:0] load_ext;
  logic        timeout_hit;

  assign cpu_req     = cpu_ren | cpu_wen;
  assign timeout_hit = (cnt_q == TimeoutLast);

  // Fault decode for the incoming request. Unsigned memops are load-only.
  always_comb begin
    req_fault = 1'b1;
    case (cpu_memop)
      3'b000:  req_fault = 1'b0;
      3'b001:  req_fault = cpu_addr[0];
      3'b010:  req_fault = |cpu_addr[1:0];
      3'b100:  req_fault = cpu_wen;
      3'b101:  req_fault = cpu_wen | cpu_addr[0];
      default: req_fault = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so the strobe alone selects bytes.
  always_comb begin
    lane_wdata = cpu_wdata;
    lane_strb  = 4'b0000;
    case (cpu_memop[1:0])
      2'b00: begin
        lane_wdata = {4{cpu_wdata[7:0]}};
        lane_strb  = 4'b0001 << cpu_addr[1:0];
      end
      2'b01: begin
        lane_wdata = {2{cpu_wdata[15:0]}};
        lane_strb  = cpu_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        lane_wdata = cpu_wdata;
        lane_strb  = 4'b1111;
      end
      default: begin
        lane_wdata = cpu_wdata;
        lane_strb  = 4'b0000;
      end
    endcase
  end

  // Load extraction uses the registered op/offset of the access in flight.
  assign load_shifted = bus_rdata >> {addr_lo_q, 3'b000};

  always_comb begin
    load_ext = bus_rdata;
    case (memop_q)
      3'b000:  load_ext = {{24{load_shifted[7]}}, load_shifted[7:0]};
      3'b001:  load_ext = {{16{load_shifted[15]}}, load_shifted[15:0]};
      3'b100:  load_ext = {24'h000000, load_shifted[7:0]};
      3'b101:  load_ext = {16'h0000, load_shifted[15:0]};
      default: load_ext = bus_rdata;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d         = state_q;
    is_store_d      = is_store_q;
    memop_d         = memop_q;
    addr_lo_d       = addr_lo_q;
    cnt_d           = cnt_q;
    cpu_rdata_d     = cpu_rdata_q;
    cpu_err_d       = 1'b0;
    bus_req_valid_d = bus_req_valid_q;
    bus_we_d        = bus_we_q;
    bus_addr_d      = bus_addr_q;
    bus_wdata_d     = bus_wdata_q;
    bus_wstrb_d     = bus_wstrb_q;

    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          is_store_d  = cpu_wen;
          memop_d     = cpu_memop;
          addr_lo_d   = cpu_addr[1:0];
          bus_we_d    = cpu_wen;
          bus_addr_d  = {cpu_addr[31:2], 2'b00};
          bus_wdata_d = lane_wdata;
          bus_wstrb_d = cpu_wen ? lane_strb : 4'b0000;
          if (req_fault) begin
            // Faulting loads return zero; faulting stores leave rdata alone.
            state_d   = StDone;
            cpu_err_d = 1'b1;
            if (!cpu_wen) begin
              cpu_rdata_d = '0;
            end
          end else begin
            state_d         = StReq;
            bus_req_valid_d = 1'b1;
            cnt_d           = '0;
          end
        end
      end

      StReq: begin
        cnt_d = cnt_q + 16'd1;
        // Acceptance cannot finish the access, so the timeout wins here.
        if (timeout_hit) begin
          state_d         = StDone;
          bus_req_valid_d = 1'b0;
          cpu_err_d       = 1'b1;
          cpu_rdata_d     = '0;
        end else if (bus_req_ready) begin
          state_d         = StResp;
          bus_req_valid_d = 1'b0;
        end
      end

      StResp: begin
        cnt_d = cnt_q + 16'd1;
        // A response on the last allowed cycle still completes normally.
        if (bus_resp_valid) begin
          state_d = StDone;
          if (!is_store_q) begin
            cpu_rdata_d = load_ext;
          end
        end else if (timeout_hit) begin
          state_d     = StDone;
          cpu_err_d   = 1'b1;
          cpu_rdata_d = '0;
        end
      end

      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      is_store_q      <= 1'b0;
      memop_q         <= 3'b000;
      addr_lo_q       <= 2'b00;
      cnt_q           <= '0;
      cpu_rdata_q     <= '0;
      cpu_err_q       <= 1'b0;
      bus_req_valid_q <= 1'b0;
      bus_we_q        <= 1'b0;
      bus_addr_q      <= '0;
      bus_wdata_q     <= '0;
      bus_wstrb_q     <= 4'b0000;
    end else begin
      state_q         <= state_d;
      is_store_q      <= is_store_d;
      memop_q         <= memop_d;
      addr_lo_q       <= addr_lo_d;
      cnt_q           <= cnt_d;
      cpu_rdata_q     <= cpu_rdata_d;
      cpu_err_q       <= cpu_err_d;
      bus_req_valid_q <= bus_req_valid_d;
      bus_we_q        <= bus_we_d;
      bus_addr_q      <= bus_addr_d;
      bus_wdata_q     <= bus_wdata_d;
      bus_wstrb_q     <= bus_wstrb_d;
    end
  end

  // In IDLE the stall must rise in the same cycle the core asks.
  always_comb begin
    cpu_stall = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle:  cpu_stall = cpu_req;
        StReq:   cpu_stall = 1'b1;
        StResp:  cpu_stall = 1'b1;
        StDone:  cpu_stall = 1'b0;
      endcase
    end
  end

  assign cpu_rdata     = cpu_rdata_q;
  assign cpu_err       = cpu_err_q;
  assign bus_req_valid = bus_req_valid_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_wstrb     = bus_wstrb_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed cases plus randomized accesses
// against a behavioural model of the load/store rules.
module tb_riscv_lsu;

  localparam int Timeout = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ren, cpu_wen;
  logic [2:0]  cpu_memop;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall, cpu_err;
  logic        bus_req_valid, bus_req_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_resp_valid;
  logic [31:0] bus_rdata;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] rdata_model;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_strb;

  always #5 clk = ~clk;

  riscv_lsu #(.TIMEOUT(Timeout)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_ren        (cpu_ren),
    .cpu_wen        (cpu_wen),
    .cpu_memop      (cpu_memop),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_stall      (cpu_stall),
    .cpu_err        (cpu_err),
    .bus_req_valid  (bus_req_valid),
    .bus_req_ready  (bus_req_ready),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_wstrb      (bus_wstrb),
    .bus_resp_valid (bus_resp_valid),
    .bus_rdata      (bus_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Access size in bytes, 0 for an illegal memop.
  function automatic int model_size(input logic [2:0] op);
    case (op)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit model_fault(input bit st, input logic [2:0] op, input logic [31:0] a);
    int sz;
    sz = model_size(op);
    if (sz == 0) return 1'b1;
    if (st && op[2]) return 1'b1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] d);
    logic [31:0] r;
    int sz;
    sz = model_size(op);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] op, input logic [31:0] a);
    int m;
    m = ((1 << model_size(op)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] rb);
    longint v;
    int     bits;
    bits = 8 * model_size(op);
    v = (longint'(rb) >> (8 * (a % 4))) & ((longint'(1) << bits) - 1);
    if (!op[2] && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  // Runs one access starting from an IDLE negedge and ends on the IDLE
  // negedge after the commit cycle. rd: wait cycles before ready (-1 never);
  // sd: wait cycles before the response; strays: random ignored pulses.
  task automatic do_access(input bit ren, input bit wen, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] d, input logic [31:0] rb,
                           input int rd, input int sd, input bit strays);
    bit          flt, timed_out, done, accepted, stable, have_p;
    int          exp_stall, exp_valid, stall_cnt, valid_cnt, wait_r, wait_s;
    bit          exp_err;
    logic [31:0] exp_rdata, p_addr, p_wdata;
    logic [3:0]  p_strb;
    logic        p_we;
    flt       = model_fault(wen, op, a);
    timed_out = !flt && (rd < 0 || rd + sd + 2 > Timeout);
    exp_valid = 0;
    if (flt) begin
      exp_stall = 1;
      exp_err   = 1'b1;
      exp_rdata = wen ? rdata_model : 32'h0;
    end else if (timed_out) begin
      exp_stall = 1 + Timeout;
      exp_err   = 1'b1;
      exp_rdata = 32'h0;
      exp_valid = (rd < 0 || rd + 1 > Timeout) ? Timeout : rd + 1;
    end else begin
      exp_stall = rd + sd + 3;
      exp_err   = 1'b0;
      exp_rdata = wen ? rdata_model : model_load(op, a, rb);
      exp_valid = rd + 1;
    end
    done = 0; accepted = 0; stable = 1; have_p = 0;
    stall_cnt = 0; valid_cnt = 0; wait_r = 0; wait_s = 0;
    p_addr = '0; p_wdata = '0; p_strb = '0; p_we = 1'b0;

    cpu_ren = ren; cpu_wen = wen; cpu_memop = op; cpu_addr = a; cpu_wdata = d;
    #1;
    check_eq("idle_stall", 32'(cpu_stall), 32'd1);
    stall_cnt = 1;
    bus_req_ready  = strays ? 1'($urandom % 2) : 1'b0;
    bus_resp_valid = strays ? 1'($urandom % 2) : 1'b0;
    bus_rdata      = $urandom;

    for (int cyc = 0; cyc < Timeout + 20 && !done; cyc++) begin
      @(negedge clk);
      bus_req_ready  = 1'b0;
      bus_resp_valid = 1'b0;
      bus_rdata      = $urandom;
      if (!cpu_stall) begin
        done = 1;
        check_eq("err", 32'(cpu_err), 32'(exp_err));
        check_eq("rdata", cpu_rdata, exp_rdata);
      end else begin
        stall_cnt++;
        if (bus_req_valid) begin
          valid_cnt++;
          if (!have_p) begin
            have_p = 1; p_addr = bus_addr; p_wdata = bus_wdata; p_strb = bus_wstrb; p_we = bus_we;
          end else if (p_addr !== bus_addr || p_wdata !== bus_wdata ||
                       p_strb !== bus_wstrb || p_we !== bus_we) begin
            stable = 0;
          end
          if (rd >= 0 && wait_r == rd) begin
            bus_req_ready = 1'b1;
            accepted = 1;
          end else begin
            wait_r++;
          end
          if (strays) bus_resp_valid = 1'($urandom % 2);
        end else if (accepted) begin
          if (wait_s == sd) begin
            bus_resp_valid = 1'b1;
            bus_rdata      = rb;
          end else begin
            wait_s++;
          end
          if (strays) bus_req_ready = 1'($urandom % 2);
        end
      end
    end

    check_eq("done_seen", 32'(done), 32'd1);
    check_eq("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
    check_eq("valid_cycles", 32'(valid_cnt), 32'(exp_valid));
    if (!flt) begin
      check_eq("payload_stable", 32'(stable), 32'd1);
      check_eq("bus_addr", p_addr, {a[31:2], 2'b00});
      check_eq("bus_we", 32'(p_we), 32'(wen));
      check_eq("bus_wstrb", 32'(p_strb), wen ? 32'(model_strb(op, a)) : 32'h0);
      if (wen) check_eq("bus_wdata", p_wdata, model_wdata(op, d));
    end
    obs_wdata   = p_wdata;
    obs_strb    = p_strb;
    rdata_model = exp_rdata;

    cpu_ren = 1'b0; cpu_wen = 1'b0;
    bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
    @(negedge clk);
    check_eq("err_one_cycle", 32'(cpu_err), 32'd0);
    check_eq("idle_after", {30'h0, cpu_stall, bus_req_valid}, 32'd0);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    bit          st, ren;
    int          sz, rd, sd;

    rst = 1'b1; cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_memop = 3'b000;
    cpu_addr = '0; cpu_wdata = '0; bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
    bus_rdata = '0; rdata_model = '0; obs_wdata = '0; obs_strb = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_rdata", cpu_rdata, 32'h0);
    check_eq("rst_ctl", {28'h0, cpu_stall, cpu_err, bus_req_valid, bus_we}, 32'h0);
    check_eq("rst_bus", bus_addr | bus_wdata | 32'(bus_wstrb), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    do_access(1, 0, 3'b010, 32'h8000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
    check_eq("lw_val", cpu_rdata, 32'hDEAD_BEEF);
    do_access(1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_0011, 0, 0, 0);
    check_eq("lb_val", cpu_rdata, 32'hFFFF_FF80);
    do_access(1, 0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_0011, 0, 0, 0);
    check_eq("lbu_val", cpu_rdata, 32'h0000_0080);
    do_access(1, 0, 3'b001, 32'h8000_0002, 32'h0, 32'h80FF_0011, 0, 0, 0);
    check_eq("lh_val", cpu_rdata, 32'hFFFF_80FF);
    do_access(0, 1, 3'b000, 32'h1000_0001, 32'h0000_00A5, 32'h0, 0, 0, 0);
    check_eq("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
    check_eq("sb_strb", 32'(obs_strb), 32'h2);
    check_eq("sb_keeps_rdata", cpu_rdata, 32'hFFFF_80FF);
    do_access(0, 1, 3'b001, 32'h1000_0002, 32'h0000_1234, 32'h0, 0, 0, 0);
    check_eq("sh_wdata", obs_wdata, 32'h1234_1234);
    check_eq("sh_strb", 32'(obs_strb), 32'hC);
    do_access(1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'h1111_2222, 5, 0, 0);
    do_access(1, 0, 3'b010, 32'h0000_0104, 32'h0, 32'h3333_4444, 0, 3, 0);
    do_access(1, 0, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 0, 0, 0);
    check_eq("flt_lw_rdata", cpu_rdata, 32'h0);
    do_access(0, 1, 3'b001, 32'h0000_0101, 32'h5555_5555, 32'h0, 0, 0, 0);
    do_access(1, 0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0, 0, 0);
    do_access(1, 1, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 0, 0, 0);
    do_access(1, 0, 3'b010, 32'h0000_0200, 32'h0, 32'h9999_9999, 0, 0, 0);
    do_access(1, 0, 3'b010, 32'h0000_0204, 32'h0, 32'h0, -1, 0, 0);
    check_eq("tmo_rdata", cpu_rdata, 32'h0);

    // Reset in RESP followed by a late response.
    cpu_ren = 1'b1; cpu_wen = 1'b0; cpu_memop = 3'b010; cpu_addr = 32'h0000_0300;
    @(negedge clk);
    bus_req_ready = 1'b1;
    @(negedge clk);
    bus_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rst_stall_low", 32'(cpu_stall), 32'd0);
    @(negedge clk);
    check_eq("rst_mid_ctl", {29'h0, cpu_err, bus_req_valid, bus_we}, 32'h0);
    check_eq("rst_mid_bus", bus_addr | bus_wdata | 32'(bus_wstrb), 32'h0);
    rst = 1'b0; cpu_ren = 1'b0;
    bus_resp_valid = 1'b1; bus_rdata = 32'hCAFE_F00D;
    rdata_model = '0;
    @(negedge clk);
    bus_resp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("late_resp_ignored", {29'h0, cpu_stall, cpu_err, bus_req_valid}, 32'h0);
      check_eq("late_resp_rdata", cpu_rdata, 32'h0);
      @(negedge clk);
    end

    // Randomized accesses with random handshake delays and stray pulses.
    for (int n = 0; n < 250; n++) begin
      st  = 1'($urandom % 2);
      ren = st ? 1'($urandom % 2) : 1'b1;
      if ($urandom_range(0, 9) < 8) begin
        case ($urandom_range(0, 4))
          0: op = 3'b000;
          1: op = 3'b001;
          2: op = 3'b010;
          3: op = 3'b100;
          default: op = 3'b101;
        endcase
      end else begin
        op = 3'($urandom_range(0, 7));
      end
      a  = $urandom;
      sz = model_size(op);
      if (sz > 0 && $urandom_range(0, 3) != 0) a = a & ~32'(sz - 1);
      rd = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 7));
      sd = int'($urandom_range(0, 3));
      do_access(ren, st, op, a, $urandom, $urandom, rd, sd, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit directly downstream of the single-cycle core's data-memory port; consumes memop, mem_wen, the ALU-result address and rs2 store data.
- Converts each access into one word-aligned bus transaction with a valid/ready request phase and a response phase.
- Produces byte strobes, byte-lane-replicated store data and sign/zero-extended load data.
- Stalls the core until the access completes; flags misaligned accesses, illegal memops and bus timeouts.

Parameters:
- TIMEOUT, 255, cycles spent in REQ+RESP before the access is aborted with error (1..65535).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- cpu_ren  input  1  load request (core MemtoReg)
- cpu_wen  input  1  store request (core mem_wen)
- cpu_memop  input  3  funct3 encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu
- cpu_addr  input  32  byte address (core mem_addr)
- cpu_wdata  input  32  store data (core memdata)
- cpu_rdata  output  32  extended load data, registered, valid when cpu_stall=0 after a load
- cpu_stall  output  1  hold PC/regfile while high
- cpu_err  output  1  access fault, high for exactly one cycle (DONE)
- bus_req_valid  output  1  request valid
- bus_req_ready  input  1  request accepted
- bus_we  output  1  1 = write
- bus_addr  output  32  {cpu_addr[31:2],2'b00}
- bus_wdata  output  32  lane-replicated store data
- bus_wstrb  output  4  byte enables, 0000 for reads
- bus_resp_valid  input  1  response (read data or write ack), one-cycle pulse
- bus_rdata  input  32  read data, valid with bus_resp_valid

Behaviour:
- Single clock clk; rst synchronous active-high. Reset: state=IDLE; cpu_rdata=0, cpu_err=0, bus_req_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_wstrb=0, timeout counter=0; cpu_stall=0 while rst=1.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - cpu_stall = cpu_ren|cpu_wen (combinational).
  - On a request: capture op, addr, lane data, strobe and we into registers.
  - Legal access → REQ.
  - Fault → DONE with err flag set, no bus activity.
  - cpu_wen and cpu_ren both high: treated as store.
- Faults:
  - h/hu/sh with addr[0]=1.
  - w with addr[1:0]≠00.
  - memop 011/110/111.
  - sb/sh/sw accept only memop 000/001/010; 100/101 on a store is a fault.
- REQ:
  - cpu_stall=1.
  - bus_req_valid=1; bus_we/addr/wdata/wstrb held stable until bus_req_ready=1.
  - On ready: valid drops next cycle, → RESP.
- RESP:
  - cpu_stall=1.
  - On bus_resp_valid: for loads, cpu_rdata ← extended bus_rdata; for stores, cpu_rdata unchanged. → DONE.
- DONE:
  - cpu_stall=0 for exactly one cycle so the core commits.
  - cpu_err=1 if the err flag is set.
  - Core request inputs ignored; → IDLE.
- Store lanes:
  - b: wdata={4{d[7:0]}}, strb=0001<<addr[1:0].
  - h: wdata={2{d[15:0]}}, strb=0011 (addr[1]=0) or 1100.
  - w: wdata=d, strb=1111.
- Load extract: lane = bus_rdata >> (8*addr[1:0]). b/h sign-extend from bit 7/15; bu/hu zero-extend.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/RESP.
  - At TIMEOUT: abort to DONE, err=1, cpu_rdata=0.
  - bus_req_valid deasserts on abort, even if never accepted.
- Stray inputs: bus_resp_valid outside RESP is ignored; so is bus_req_ready outside REQ.
- Reset mid-transaction: immediate return to IDLE with reset values; a late response is ignored.
- Minimum latency (ready and resp same cycle they are awaited): stall high for 3 cycles, commit in the 4th; back-to-back accesses therefore cost 4 cycles each.
- Fault latency: stall 1 cycle, then DONE with err.

Test Plan:
- lw addr=0x80000004, ready/resp immediate, rdata=0xDEADBEEF → bus_addr=0x80000004, strb=0000, we=0; stall high 3 cycles; cpu_rdata=0xDEADBEEF in DONE, cpu_err=0.
- lb addr=0x80000003, rdata=0x80FF0011 → cpu_rdata=0xFFFFFF80. Same with lbu → 0x00000080. lh addr=0x...2 → 0xFFFF80FF.
- sb addr=0x10000001, wdata=0x000000A5 → wdata=0xA5A5A5A5, strb=0010, we=1. sh addr=0x...2 wdata=0x1234 → wdata=0x12341234, strb=1100.
- bus_req_ready held low 5 cycles → valid and payload stable all 5 cycles, single acceptance. bus_resp_valid 3 cycles late → stall extends by 3 cycles.
- lw addr=0x...2, then sh addr=0x...1, then memop=011 → no bus_req_valid; each: stall 1 cycle, cpu_err=1 for one cycle, cpu_rdata=0 for the load.
- TIMEOUT=8, ready never asserted → abort after 8 cycles, err pulse, valid drops. Also: rst mid-RESP followed by a stray bus_resp_valid → state IDLE, outputs at reset values, no DONE.
